// File: rtl/int_to_fp_conv_if.sv
// Handshake and operand/result bundle between an integer source and int_to_fp_conv.
// The magnitude width is tied to the exponent width so every nonzero input has a representable exponent.
interface int_to_fp_conv_if #(
  parameter int EXP_W  = 4,
  parameter int FRAC_W = 8
);
  localparam int MAG_W = (1 << EXP_W) - 1;

  logic              start;
  logic              sign_in;
  logic [MAG_W-1:0]  mag_in;
  logic              ready;
  logic              done;
  logic              sign_out;
  logic [EXP_W-1:0]  exp_out;
  logic [FRAC_W-1:0] frac_out;

  modport master (
    output start, sign_in, mag_in,
    input  ready, done, sign_out, exp_out, frac_out
  );

  modport slave (
    input  start, sign_in, mag_in,
    output ready, done, sign_out, exp_out, frac_out
  );
endinterface

// File: rtl/int_to_fp_conv.sv
// Sign-magnitude integer to 0.frac x 2^exp float converter; normalizes one left shift per cycle.
// Results are registered and held until the next conversion writes them.
module int_to_fp_conv #(
  parameter int EXP_W  = 4,
  parameter int FRAC_W = 8
) (
  input  logic clk,
  input  logic reset,
  int_to_fp_conv_if.slave bus
);
  localparam int MAG_W = (1 << EXP_W) - 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_NORM = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [MAG_W-1:0]  shreg_q, shreg_d;
  logic [EXP_W-1:0]  e_q, e_d;
  logic              sign_lat_q, sign_lat_d;
  logic              sign_out_q, sign_out_d;
  logic [EXP_W-1:0]  exp_out_q, exp_out_d;
  logic [FRAC_W-1:0] frac_out_q, frac_out_d;

  always_comb begin
    // NOTE: every variable gets a hold-value default first so no path leaves it unassigned (no latch).
    state_d    = state_q;
    shreg_d    = shreg_q;
    e_d        = e_q;
    sign_lat_d = sign_lat_q;
    sign_out_d = sign_out_q;
    exp_out_d  = exp_out_q;
    frac_out_d = frac_out_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.mag_in == '0) begin
            // Zero has a single encoding; negative zero is written as positive.
            sign_out_d = 1'b0;
            exp_out_d  = '0;
            frac_out_d = '0;
            state_d    = S_DONE;
          end else begin
            shreg_d    = bus.mag_in;
            e_d        = '1;
            sign_lat_d = bus.sign_in;
            state_d    = S_NORM;
          end
        end
      end
      S_NORM: begin
        if (shreg_q[MAG_W-1]) begin
          // Lower magnitude bits are truncated, not rounded.
          frac_out_d = shreg_q[MAG_W-1 -: FRAC_W];
          exp_out_d  = e_q;
          sign_out_d = sign_lat_q;
          state_d    = S_DONE;
        end else begin
          shreg_d = shreg_q << 1;
          e_d     = e_q - EXP_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      shreg_q    <= '0;
      e_q        <= '0;
      sign_lat_q <= 1'b0;
      sign_out_q <= 1'b0;
      exp_out_q  <= '0;
      frac_out_q <= '0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      e_q        <= e_d;
      sign_lat_q <= sign_lat_d;
      sign_out_q <= sign_out_d;
      exp_out_q  <= exp_out_d;
      frac_out_q <= frac_out_d;
    end
  end

  assign bus.ready    = (state_q == S_IDLE);
  assign bus.done     = (state_q == S_DONE);
  assign bus.sign_out = sign_out_q;
  assign bus.exp_out  = exp_out_q;
  assign bus.frac_out = frac_out_q;
endmodule

// File: tb/tb_int_to_fp_conv.sv
// Directed bench for int_to_fp_conv: hand-computed results, latencies, reset abort and back-to-back starts.
module tb_int_to_fp_conv;
  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  int_to_fp_conv_if #(.EXP_W(4), .FRAC_W(8)) bus ();

  int_to_fp_conv #(.EXP_W(4), .FRAC_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // One conversion from the idle state; latency is counted in cycles after the accept edge.
  task automatic convert(input string tag, input logic s, input logic [14:0] m,
                         input int exp_lat, input logic es, input logic [3:0] ee,
                         input logic [7:0] ef, input bit poke);
    int n;
    bit rdy_bad;
    check({tag, " ready_idle"}, 32'(bus.ready), 32'd1);
    bus.start   = 1'b1;
    bus.sign_in = s;
    bus.mag_in  = m;
    @(posedge clk); #1;
    bus.start   = 1'b0;
    bus.sign_in = ~s;
    bus.mag_in  = ~m;
    n = 0;
    rdy_bad = 1'b0;
    while (!bus.done && n < 40) begin
      if (bus.ready) rdy_bad = 1'b1;
      if (poke && n == 3) begin
        bus.start  = 1'b1;
        bus.mag_in = 15'h7FFF;
      end
      if (poke && n == 4) bus.start = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    bus.start = 1'b0;
    check({tag, " latency"},    32'(n),            32'(exp_lat));
    check({tag, " ready_busy"}, 32'(rdy_bad),      32'd0);
    check({tag, " ready_done"}, 32'(bus.ready),    32'd0);
    check({tag, " sign"},       32'(bus.sign_out), 32'(es));
    check({tag, " exp"},        32'(bus.exp_out),  32'(ee));
    check({tag, " frac"},       32'(bus.frac_out), 32'(ef));
    @(posedge clk); #1;
    check({tag, " done_width"}, 32'(bus.done),     32'd0);
    check({tag, " ready_back"}, 32'(bus.ready),    32'd1);
    check({tag, " exp_hold"},   32'(bus.exp_out),  32'(ee));
  endtask

  initial begin
    int  done_seen;
    int  last_done;
    int  done_cnt;
    int  rdy_cnt;
    int  n;

    reset       = 1'b0;
    bus.start   = 1'b0;
    bus.sign_in = 1'b0;
    bus.mag_in  = '0;
    #12;
    check("reset ready",    32'(bus.ready),    32'd1);
    check("reset done",     32'(bus.done),     32'd0);
    check("reset sign",     32'(bus.sign_out), 32'd0);
    check("reset exp",      32'(bus.exp_out),  32'd0);
    check("reset frac",     32'(bus.frac_out), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    convert("m4000", 1'b0, 15'h4000, 1,  1'b0, 4'hF, 8'h80, 1'b0);
    convert("m0001", 1'b1, 15'h0001, 15, 1'b1, 4'h1, 8'h80, 1'b1);
    convert("m00b7", 1'b0, 15'h00B7, 8,  1'b0, 4'h8, 8'hB7, 1'b0);
    convert("m7fff", 1'b0, 15'h7FFF, 1,  1'b0, 4'hF, 8'hFF, 1'b0);

    // Abort a long conversion with reset while results are nonzero.
    bus.start  = 1'b1;
    bus.mag_in = 15'h0001;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("abort ready", 32'(bus.ready),    32'd1);
    check("abort done",  32'(bus.done),     32'd0);
    check("abort sign",  32'(bus.sign_out), 32'd0);
    check("abort exp",   32'(bus.exp_out),  32'd0);
    check("abort frac",  32'(bus.frac_out), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.done) done_seen++;
    end
    check("abort no_done", 32'(done_seen), 32'd0);
    convert("after_abort", 1'b0, 15'h00B7, 8, 1'b0, 4'h8, 8'hB7, 1'b0);

    convert("negzero", 1'b1, 15'h0000, 0, 1'b0, 4'h0, 8'h00, 1'b0);

    // start held high: accepts land one cycle after each done, giving a 9-cycle period.
    bus.start   = 1'b1;
    bus.sign_in = 1'b0;
    bus.mag_in  = 15'h0100;
    @(posedge clk); #1;
    last_done = -1;
    done_cnt  = 0;
    rdy_cnt   = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) begin
        if (last_done >= 0) check("b2b spacing", 32'(i - last_done), 32'd9);
        else                check("b2b first",   32'(i),             32'd7);
        check("b2b sign", 32'(bus.sign_out), 32'd0);
        check("b2b exp",  32'(bus.exp_out),  32'h9);
        check("b2b frac", 32'(bus.frac_out), 32'h80);
        last_done = i;
        done_cnt++;
      end
      if (bus.ready) begin
        check("b2b ready_pos", 32'(i), 32'(last_done + 1));
        rdy_cnt++;
      end
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    check("b2b done_cnt",  32'(done_cnt), 32'd4);
    check("b2b ready_cnt", 32'(rdy_cnt),  32'd4);
    n = 0;
    while (!bus.done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("b2b drain_done", 32'(bus.done),    32'd1);
    check("b2b drain_exp",  32'(bus.exp_out), 32'h9);
    @(posedge clk); #1;
    check("b2b final_ready", 32'(bus.ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
